// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types and constants.
// Used by uart_rx_byte and uart_pixel_rx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int mid_bit(input int clks);
    return clks / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchronizer, bit FSM and baud counter.
// Define UART_RX_PARITY_EN to expect an even-parity bit after D7.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_active,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(mid_bit(CLKS_PER_BIT) - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic          tick_half;
  logic          tick_full;
  logic          stop_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick_half = (cnt == HALF);
  assign tick_full = (cnt == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_active <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync)
            state <= START;
        end
        START: begin
          if (tick_half) begin
            cnt <= '0;
            if (!rx_sync) begin
              state     <= DATA;
              bit_idx   <= '0;
              rx_active <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT)
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_full) begin
            cnt <= '0;
            // a bad parity byte still has its stop bit on the line
            if (^{shreg, rx_sync})
              state <= WAIT_HIGH;
            else
              state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_full) begin
            cnt <= '0;
            if (rx_sync) begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_sync) begin
            state     <= IDLE;
            rx_active <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

  assign byte_data  = shreg;
  assign byte_valid = (state == STOP) && tick_full && rx_sync;
  assign stop_err   = (state == STOP) && tick_full && !rx_sync;

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign par_err  = (state == PARITY) && tick_full &&
                    (^{shreg, rx_sync});
  assign byte_err = stop_err | par_err;
`else
  assign byte_err = stop_err;
`endif

endmodule

// File: rtl/uart_pixel_rx.sv
// uart_pixel_rx: UART byte stream to sequential pixel writes.
// Define UART_RX_PARITY_EN to expect even parity on every byte.
module uart_pixel_rx
  import uart_pkg::*;
#(
  parameter int HIEGHT       = 30,
  parameter int WIDTH        = 30,
  parameter int BPP          = 3,
  parameter int PEXILS       = HIEGHT * WIDTH,
  parameter int CLKS_PER_BIT = 434,
  parameter int SZ           = 8 * BPP
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      clear,
  output logic                      wr_en,
  output logic [$clog2(PEXILS)-1:0] wr_addr,
  output logic [SZ-1:0]             pixel_out,
  output logic                      rx_active,
  output logic                      frame_done,
  output logic                      frame_err
);

  localparam int AW = $clog2(PEXILS);
  localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(PEXILS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPP - 1);

  logic          byte_valid;
  logic          byte_err;
  logic [7:0]    byte_data;
  logic [BW-1:0] byte_cnt;
  logic [SZ-1:0] acc;
  logic [SZ-1:0] acc_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_active (rx_active),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err)
  );

  // earlier bytes shift toward the MSB end
  assign acc_next = SZ'({acc, byte_data});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      pixel_out  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt   <= '0;
      acc        <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= byte_err;
      if (clear) begin
        byte_cnt <= '0;
        acc      <= '0;
        wr_addr  <= '0;
      end else begin
        if (wr_en)
          wr_addr <= (wr_addr == LAST_ADDR) ?
                     '0 : wr_addr + 1'b1;
        if (byte_err) begin
          byte_cnt <= '0;
          acc      <= '0;
        end else if (byte_valid) begin
          acc <= acc_next;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt   <= '0;
            wr_en      <= 1'b1;
            pixel_out  <= acc_next;
            frame_done <= (wr_addr == LAST_ADDR);
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// tb_uart_pixel_rx: table vectors, corner sequences and random
// bytes checked against a queue-based pixel model.
`timescale 1ns/1ps
module tb_uart_pixel_rx;

  localparam int CPB  = 16;
  localparam int BPP  = 3;
  localparam int H    = 2;
  localparam int W    = 2;
  localparam int NPIX = H * W;
  localparam int SZ   = 8 * BPP;
  localparam int AW   = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  // stop mid-bit plus 2-flop sync plus edge register
  localparam int LAT = FBITS * CPB - CPB / 2 + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          clear = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [SZ-1:0] pixel_out;
  logic          rx_active;
  logic          frame_done;
  logic          frame_err;

  uart_pixel_rx #(
    .HIEGHT(H), .WIDTH(W), .BPP(BPP),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .pixel_out(pixel_out), .rx_active(rx_active),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SZ-1:0] pix;
    logic          done;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [7:0]    b0, b1, b2;
    logic [SZ-1:0] pix;
    logic [AW-1:0] addr;
    logic          done;
  } vec_t;

  wr_t  act_q[$];
  wr_t  exp_q[$];
  vec_t tbl[5];
  int   lat_start[5];

  int   tests = 0, fails = 0;
  int   cyc = 0, err_cnt = 0, rise_cnt = 0, stray_done = 0;
  int   last_start = 0;
  logic act_d = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en)
      act_q.push_back('{wr_addr, pixel_out, frame_done, cyc});
    else if (frame_done)
      stray_done++;
    if (frame_err) err_cnt++;
    if (rx_active && !act_d) rise_cnt++;
    act_d = rx_active;
  end

  // reference model: whole bytes in, whole pixels out
  int         m_addr = 0;
  int         m_err = 0;
  logic [7:0] m_pend[$];

  function automatic void m_byte(input logic [7:0] b,
                                 input bit ok);
    wr_t w;
    if (!ok) begin
      m_pend.delete();
      m_err++;
      return;
    end
    m_pend.push_back(b);
    if (m_pend.size() == BPP) begin
      w.addr = AW'(m_addr);
      w.pix  = {m_pend[0], m_pend[1], m_pend[2]};
      w.done = (m_addr == NPIX - 1);
      w.cyc  = 0;
      exp_q.push_back(w);
      m_addr = (m_addr + 1) % NPIX;
      m_pend.delete();
    end
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit stop_ok = 1'b1,
                            input bit par_ok = 1'b1);
    last_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ !par_ok);
`endif
    send_bit(stop_ok);
    if (!stop_ok) send_bit(1'b1);
    m_byte(d, stop_ok && par_ok);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_pend.delete();
    m_addr = 0;
  endtask

  task automatic compare_all(input string tag);
    wr_t a, e;
    repeat (4) @(posedge clk); #1;
    check({tag, " write count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " addr"}, a.addr, e.addr);
      check({tag, " pixel"}, a.pix, e.pix);
      check({tag, " frame_done"}, a.done, e.done);
    end
    check({tag, " frame_err count"}, err_cnt, m_err);
    check({tag, " stray frame_done"}, stray_done, 0);
    act_q.delete(); exp_q.delete();
    err_cnt = 0; m_err = 0; stray_done = 0; rise_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hAA, 8'h55, 8'h0F, 24'hAA550F, 2'd0, 1'b0};
    tbl[1] = '{8'h12, 8'h34, 8'h56, 24'h123456, 2'd1, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF, 24'hFF00FF, 2'd2, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 8'h7E, 24'h80017E, 2'd3, 1'b1};
    tbl[4] = '{8'hC3, 8'h3C, 8'h99, 24'hC33C99, 2'd0, 1'b0};

    #2 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset wr_en", wr_en, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset pixel_out", pixel_out, 0);
    check("reset rx_active", rx_active, 0);
    check("reset frame_done", frame_done, 0);
    check("reset frame_err", frame_err, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    act_q.delete(); err_cnt = 0; rise_cnt = 0;

    // table: 15 back-to-back bytes, wraps after addr 3
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].b0);
      send_frame(tbl[i].b1);
      lat_start[i] = cyc;
      send_frame(tbl[i].b2);
    end
    check("table write count", act_q.size(), 5);
    check("table rx_active rises", rise_cnt, 15);
    for (int i = 0; i < 5 && i < act_q.size(); i++) begin
      check("table addr", act_q[i].addr, tbl[i].addr);
      check("table pixel", act_q[i].pix, tbl[i].pix);
      check("table frame_done", act_q[i].done, tbl[i].done);
      tests++;
      if (act_q[i].cyc - lat_start[i] < LAT - 2 ||
          act_q[i].cyc - lat_start[i] > LAT + 2) begin
        fails++;
        $display("FAIL table latency: got %0d expected %0d+-2",
                 act_q[i].cyc - lat_start[i], LAT);
      end
    end
    compare_all("table");

    // framing error discards the partial pixel
    do_clear();
    send_frame(8'h11);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33);
    send_frame(8'h44);
    send_frame(8'h55);
    check("ferr single write", act_q.size(), 1);
    if (act_q.size() > 0)
      check("ferr pixel", act_q[0].pix, 24'h334455);
    check("ferr pulses", err_cnt, 1);
    compare_all("ferr");

    // short glitch in idle
    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx = 1'b1;
    repeat (200) @(posedge clk); #1;
    check("glitch rx_active rises", rise_cnt, 0);
    compare_all("glitch");

    // clear after one byte
    send_frame(8'h01);
    do_clear();
    send_frame(8'h02);
    send_frame(8'h03);
    send_frame(8'h04);
    compare_all("clear");

    // break: rx held low well past the stop bit
    send_frame(8'h5A);
    rx = 1'b0;
    repeat (20 * CPB) @(posedge clk); #1;
    check("break rx_active held", rx_active, 1);
    m_byte(8'h00, 1'b0);
    rx = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("break rx_active released", rx_active, 0);
    send_frame(8'hDE);
    send_frame(8'hAD);
    send_frame(8'hBE);
    compare_all("break");

    // async reset in the middle of a byte
    do_clear();
    send_frame(8'hA1);
    send_frame(8'hB2);
    send_frame(8'hC3);
    compare_all("prereset");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    #1;
    check("midrst wr_addr", wr_addr, 0);
    check("midrst pixel_out", pixel_out, 0);
    check("midrst rx_active", rx_active, 0);
    check("midrst wr_en", wr_en, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    m_pend.delete(); m_addr = 0;
    repeat (3) @(posedge clk); #1;
    act_q.delete(); err_cnt = 0; rise_cnt = 0;
    send_frame(8'h0A);
    send_frame(8'h0B);
    send_frame(8'h0C);
    compare_all("postreset");

`ifdef UART_RX_PARITY_EN
    do_clear();
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07);
    send_frame(8'h70);
    send_frame(8'hE1);
    compare_all("parity");
`endif

    // random bytes with occasional framing errors
    do_clear();
    for (int i = 0; i < 45; i++)
      send_frame(8'($urandom), $urandom_range(7) != 0);
    compare_all("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
